ro_deserializer: RTL
====================

# ro_deserializer

Downstream consumer of the shared readout lines driven by the per-channel readout blocks.
- Each `clk_master` cycle, exactly one channel's tri-state pair owns the lines: the channel whose gray-counter bit toggled on that edge.
- The block keeps a counter aligned with the on-chip gray counter and decodes which channel owns each cycle.
- It samples the event/polarity lines and packs each detected event with channel index and timestamp into a buffered valid/ready stream for the host interface.

## Interface
Parameters:
- `N_CH`, 19: number of readout channels; also the gray-counter width.
- `TS_W`, 16: timestamp width (low bits of the cycle counter).
- `DEPTH`, 8: event FIFO depth (power of two).

Ports:
- `clk_master` input 1: the single clock, same master clock that drives the on-chip gray counter.
- `rstb` input 1: asynchronous, active-low reset.
- `en` input 1: capture enable; counter runs regardless.
- `bus_eve` input 1: shared event line (`out_mux_eve`), bus-keeper held through the low phase.
- `bus_pol_eve` input 1: shared polarity line (`out_mux_pol_eve`).
- `ev_valid` output 1: event word available.
- `ev_ready` input 1: consumer accepts the word.
- `ev_data` output `TS_W+5+1`: event word `{ts, ch[4:0], pol}`.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.
- `drop_cnt` output 8: dropped-event count, saturating at 255.

## Operation
- **Cycle counter.** `cnt` is `N_CH` bits, binary, 0 at reset, +1 every `clk_master` posedge, wraps from 2^N_CH−1 to 0. It mirrors the on-chip gray counter: gray(`cnt`) equals the chip value, and both are reset by `rstb`.
- **Slot decode.**
  - After the posedge that loads `cnt = c`, the owning channel is `ch = ctz(c)`, the trailing-zero count of `c`.
  - On wrap to `c = 0`, `ch = N_CH−1`.
  - Implement `ctz` as a priority encoder.
- **Slot pipeline.** On each posedge, `slot_ch <= ch(cnt_next)`, `slot_ts <= cnt_next[TS_W-1:0]`, `slot_v <= 1`. `slot_v` is 0 from reset until the first posedge.
- **Capture.** At the next posedge, if `slot_v & en & bus_eve`, form the word `{slot_ts, slot_ch, bus_pol_eve}` and present it as a push to the FIFO. If `bus_eve = 0`, nothing is pushed.
- **FIFO.**
  - Depth `DEPTH`; `ev_data` shows the head entry.
  - Pop when `ev_valid & ev_ready`.
  - A push while full is accepted only if a pop occurs in the same cycle. Otherwise the event is dropped: `overflow <= 1` and `drop_cnt` increments, saturating at 255.
  - Push and pop together on empty: the push lands and `ev_valid` rises next cycle. There is no fall-through.
- **`en` low.** Suppresses pushes only. FIFO draining continues.

## Timing
- Reset values:
  - `cnt = 0`, `slot_v = 0`
  - FIFO empty, `ev_valid = 0`, `ev_data = 0`
  - `overflow = 0`, `drop_cnt = 0`
- Reset is asynchronous assert and synchronous-to-`clk_master` deassert (the deassert synchroniser lives outside this block). Asserting reset mid-operation discards every FIFO entry and the in-flight slot.
- Latency:
  - Slot owned after posedge k is sampled at posedge k+1.
  - The word is written at posedge k+1.
  - `ev_valid` is high after posedge k+1 when the FIFO was empty, i.e. 1 cycle sample-to-valid.
- `ev_data` stays stable while `ev_valid & ~ev_ready` (AXI-style hold).
- `ch` is always in 0..N_CH−1; `ts` wraps modulo 2^TS_W with no flag.

## Structure
- Package `ro_pkg` holds `N_CH`, `TS_W`, `CH_W = 5`, `EV_W = TS_W + CH_W + 1`, and the event-word field offsets. Share it with the host-interface block.
- One sub-module, `ro_evt_fifo`: synchronous FIFO with `clk_master`/`rstb`, push/pop, full/empty, and an accept signal for the full-with-pop case.
- The priority encoder and counter stay inline.

## Test plan
- **Reset.** Hold `rstb = 0` with the bus toggling → all outputs 0. Release and run 8 cycles with `bus_eve = 0` → `ev_valid` never rises, `cnt = 8`.
- **Slot decode.** `bus_eve = 1` every cycle, `ev_ready = 1`, `en = 1` → the `ch` sequence is 0,1,0,2,0,1,0,3,…, and `ts` equals 1,2,3,… with `pol` = `bus_pol_eve` sampled.
- **Wrap.** Force `N_CH = 4` and run 16 cycles with `bus_eve = 1` → the word with `ts` low bits 0 carries `ch = 3`; ctz values before wrap match the gray reference model.
- **Overflow.** `ev_ready = 0`, `bus_eve = 1` for 12 cycles, `DEPTH = 8` → 8 words stored, `overflow = 1`, `drop_cnt = 4`. Then `ev_ready = 1` → the 8 words drain in order with original `ts`.
- **Full with simultaneous push/pop.** With the FIFO full and `ev_ready = 1` and `bus_eve = 1` in the same cycle → no drop, `drop_cnt` unchanged, occupancy stays 8.
- **Mid-operation reset and `en`.** `en = 0` suppresses pushes while draining continues. Assert `rstb` with 5 words queued → `ev_valid` falls immediately (async). After release, the first event has `ts = 1`.

Source files
------------

// File: rtl/ro_pkg.sv
// ro_pkg: shared readout parameters and event-word layout for the deserializer and host interface
package ro_pkg;
    localparam int N_CH       = 19;
    localparam int TS_W       = 16;
    localparam int CH_W       = 5;
    localparam int EV_W       = TS_W + CH_W + 1;
    localparam int DEPTH      = 8;
    localparam int EV_POL_LSB = 0;
    localparam int EV_CH_LSB  = 1;
    localparam int EV_TS_LSB  = CH_W + 1;
endpackage

// File: rtl/ro_evt_fifo.sv
// ro_evt_fifo: synchronous event FIFO; a push while full lands only when a pop frees the slot in the same cycle
module ro_evt_fifo
    import ro_pkg::*;
#(
    parameter int W     = EV_W,
    parameter int DEPTH = ro_pkg::DEPTH
) (
    input  logic         clk_master,
    input  logic         rstb,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         accept_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         pop_ok;
    assign empty_o  = wr_q == rd_q;
    assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok   = pop_i & ~empty_o;
    assign accept_o = push_i & (~full_o | pop_ok);
    assign wr_d     = wr_q + (AW+1)'(accept_o);
    assign rd_d     = rd_q + (AW+1)'(pop_ok);
    assign dout_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk_master) begin
        if (accept_o) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/ro_deserializer.sv
// ro_deserializer: tracks the chip gray counter, decodes the owning channel per cycle and buffers captured events
module ro_deserializer
    import ro_pkg::*;
#(
    parameter int N_CH  = ro_pkg::N_CH,
    parameter int TS_W  = ro_pkg::TS_W,
    parameter int DEPTH = ro_pkg::DEPTH
) (
    input  logic               clk_master,
    input  logic               rstb,
    input  logic               en,
    input  logic               bus_eve,
    input  logic               bus_pol_eve,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [TS_W+CH_W:0] ev_data,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);
    logic [N_CH-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0] ch_d, slot_ch_q;
    logic [TS_W-1:0] slot_ts_q;
    logic            slot_v_q, overflow_q;
    logic [7:0]      drop_cnt_q;
    logic            push, pop, acc, full, empty, drop;
    assign cnt_d = cnt_q + N_CH'(1);
    // The gray bit that toggles is the lowest set bit of the new count; zero means the MSB wrapped.
    always_comb begin
        ch_d = CH_W'(N_CH - 1);
        for (int i = N_CH - 1; i >= 0; i--)
            if (cnt_d[i]) ch_d = CH_W'(i);
    end
    assign push     = slot_v_q & en & bus_eve;
    assign pop      = ev_valid & ev_ready;
    assign drop     = push & full & ~acc;
    assign ev_valid = ~empty;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            cnt_q      <= '0;
            slot_ch_q  <= '0;
            slot_ts_q  <= '0;
            slot_v_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            slot_ch_q  <= ch_d;
            slot_ts_q  <= cnt_d[TS_W-1:0];
            slot_v_q   <= 1'b1;
            overflow_q <= overflow_q | drop;
            drop_cnt_q <= (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        end
    end
    ro_evt_fifo #(.W(TS_W + CH_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk_master(clk_master),
        .rstb      (rstb),
        .push_i    (push),
        .pop_i     (pop),
        .din_i     ({slot_ts_q, slot_ch_q, bus_pol_eve}),
        .dout_o    (ev_data),
        .full_o    (full),
        .empty_o   (empty),
        .accept_o  (acc)
    );
endmodule
